// File: rtl/mpu_controller.sv
// mpu_controller: sequences matrix LOAD/STORE requests against a small register file
// and tracks which registers hold a loaded matrix.
// Operation encoding on op: 2'd0 = NOP, 2'd1 = LOAD, 2'd2 = STORE (2'd3 is answered with error).
// Optional build macro MPU_CTRL_TIMEOUT_EN adds a busy-state watchdog of TIMEOUT cycles;
// without it the busy states wait for an ack indefinitely.
module mpu_controller #(
    parameter int FP              = 32,
    parameter int M               = 2,
    parameter int N               = 2,
    parameter int MBITS           = 1,
    parameter int NBITS           = 1,
    parameter int MATRIX_REG_SIZE = 1,
    parameter int TIMEOUT         = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              op_valid,
    input  logic [1:0]                        op,
    input  logic [MATRIX_REG_SIZE-1:0]        op_addr,
    input  logic [MBITS:0]                    op_m,
    input  logic [NBITS:0]                    op_n,
    output logic                              op_ready,
    output logic                              done,
    output logic                              error,
    output logic                              load_en,
    input  logic                              load_ack,
    input  logic                              load_error,
    output logic [MATRIX_REG_SIZE-1:0]        load_addr,
    output logic [MBITS:0]                    matrix_m_size,
    output logic [NBITS:0]                    matrix_n_size,
    output logic                              store_en,
    input  logic                              store_ack,
    output logic [MATRIX_REG_SIZE-1:0]        reg_store_addr,
    output logic [(2**MATRIX_REG_SIZE)-1:0]   reg_valid
);

    localparam int unsigned MW = MBITS + 1;
    localparam int unsigned NW = NBITS + 1;
    localparam logic [1:0]  OP_NOP   = 2'd0;
    localparam logic [1:0]  OP_LOAD  = 2'd1;
    localparam logic [1:0]  OP_STORE = 2'd2;

    // Reject nonsensical configurations at elaboration time
    if (FP < 1 || M < 1 || N < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mpu_controller: FP, M, N and TIMEOUT must all be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_BUSY,
        S_STORE_BUSY,
        S_RESP
    } state_t;

    state_t state;
    logic   dims_ok;

    // Requested matrix shape fits within the M x N register geometry
    always_comb begin
        dims_ok = (op_m != '0) && (op_m <= MW'(M)) && (op_n != '0) && (op_n <= NW'(N));
    end

`ifdef MPU_CTRL_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic          wd_expired;

    // Watchdog fires on the TIMEOUT-th busy cycle without an ack
    always_comb begin
        wd_expired = (wd_cnt == CW'(TIMEOUT - 1));
    end
`endif

    // Controller FSM with registered handshake, status and operand outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            op_ready       <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            load_en        <= 1'b0;
            store_en       <= 1'b0;
            load_addr      <= '0;
            reg_store_addr <= '0;
            matrix_m_size  <= '0;
            matrix_n_size  <= '0;
            reg_valid      <= '0;
`ifdef MPU_CTRL_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    op_ready <= 1'b1;
                    if (op_valid && op_ready) begin
                        op_ready       <= 1'b0;
                        load_addr      <= op_addr;
                        reg_store_addr <= op_addr;
                        matrix_m_size  <= op_m;
                        matrix_n_size  <= op_n;
                        state          <= S_RESP;
                        case (op)
                            OP_NOP: done <= 1'b1;
                            OP_LOAD: begin
                                if (dims_ok) begin
                                    reg_valid[op_addr] <= 1'b0;
                                    load_en            <= 1'b1;
                                    state              <= S_LOAD_BUSY;
                                end else begin
                                    error <= 1'b1;
                                end
                            end
                            OP_STORE: begin
                                if (reg_valid[op_addr]) begin
                                    store_en <= 1'b1;
                                    state    <= S_STORE_BUSY;
                                end else begin
                                    error <= 1'b1;
                                end
                            end
                            default: error <= 1'b1;
                        endcase
                    end
                end
                S_LOAD_BUSY: begin
                    if (load_ack) begin
                        load_en <= 1'b0;
                        state   <= S_RESP;
                        if (load_error) begin
                            error <= 1'b1;
                        end else begin
                            done                 <= 1'b1;
                            reg_valid[load_addr] <= 1'b1;
                        end
`ifdef MPU_CTRL_TIMEOUT_EN
                        wd_cnt <= '0;
                    end else if (wd_expired) begin
                        load_en <= 1'b0;
                        error   <= 1'b1;
                        state   <= S_RESP;
                        wd_cnt  <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
`endif
                    end
                end
                S_STORE_BUSY: begin
                    if (store_ack) begin
                        store_en <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_RESP;
`ifdef MPU_CTRL_TIMEOUT_EN
                        wd_cnt   <= '0;
                    end else if (wd_expired) begin
                        store_en <= 1'b0;
                        error    <= 1'b1;
                        state    <= S_RESP;
                        wd_cnt   <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
`endif
                    end
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_controller.sv
// tb_mpu_controller: directed and randomized request sequences for mpu_controller,
// checked against a transaction-level model of the register-valid flags and outcomes.
module tb_mpu_controller;

    localparam int unsigned NREG = 2;
    localparam logic [1:0]  NOP   = 2'd0;
    localparam logic [1:0]  LOAD  = 2'd1;
    localparam logic [1:0]  STORE = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op;
    logic        op_addr;
    logic [1:0]  op_m;
    logic [1:0]  op_n;
    logic        op_ready;
    logic        done;
    logic        error;
    logic        load_en;
    logic        load_ack;
    logic        load_error;
    logic        load_addr;
    logic [1:0]  matrix_m_size;
    logic [1:0]  matrix_n_size;
    logic        store_en;
    logic        store_ack;
    logic        reg_store_addr;
    logic [1:0]  reg_valid;

    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    bit [NREG-1:0] model_valid;

    mpu_controller #(
        .FP(32), .M(2), .N(2), .MBITS(1), .NBITS(1), .MATRIX_REG_SIZE(1), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_addr(op_addr),
        .op_m(op_m), .op_n(op_n), .op_ready(op_ready), .done(done), .error(error),
        .load_en(load_en), .load_ack(load_ack), .load_error(load_error),
        .load_addr(load_addr), .matrix_m_size(matrix_m_size), .matrix_n_size(matrix_n_size),
        .store_en(store_en), .store_ack(store_ack), .reg_store_addr(reg_store_addr),
        .reg_valid(reg_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        op_valid = 1'b0; op = NOP; op_addr = 1'b0; op_m = 2'd0; op_n = 2'd0;
        load_ack = 1'b0; load_error = 1'b0; store_ack = 1'b0;
    endtask

    // One request from IDLE to the next IDLE; called and returning at a falling edge
    task automatic run_op(input logic [1:0] o, input logic a, input logic [1:0] m,
                          input logic [1:0] n, input int lat, input logic lerr, input bit stray);
        int  kind;   // 0 immediate done, 1 immediate error, 2 load busy, 3 store busy
        bit  dims_ok;
        bit  exp_err;
        dims_ok = (m >= 2'd1) && (m <= 2'd2) && (n >= 2'd1) && (n <= 2'd2);
        if (o == NOP)       kind = 0;
        else if (o == LOAD) kind = dims_ok ? 2 : 1;
        else                kind = model_valid[a] ? 3 : 1;

        check("ready_before_req", 32'(op_ready), 1);
        op_valid = 1'b1; op = o; op_addr = a; op_m = m; op_n = n;
        @(negedge clk);
        op_valid = 1'b0;
        check("ready_after_accept", 32'(op_ready), 0);
        check("load_addr_latched", 32'(load_addr), 32'(a));
        check("store_addr_latched", 32'(reg_store_addr), 32'(a));
        check("m_size_latched", 32'(matrix_m_size), 32'(m));
        check("n_size_latched", 32'(matrix_n_size), 32'(n));

        if (kind < 2) begin
            check("resp_done", 32'(done), 32'(kind == 0));
            check("resp_error", 32'(error), 32'(kind == 1));
            check("resp_load_en", 32'(load_en), 0);
            check("resp_store_en", 32'(store_en), 0);
            check("resp_reg_valid", 32'(reg_valid), 32'(model_valid));
            if (stray) begin
                load_ack = 1'b1; store_ack = 1'b1;
            end
            @(negedge clk);
            load_ack = 1'b0; store_ack = 1'b0;
        end else begin
            if (kind == 2) model_valid[a] = 1'b0;
            check("busy_reg_valid", 32'(reg_valid), 32'(model_valid));
            check("busy_done", 32'(done | error), 0);
            if (stray) begin
                if (kind == 2) store_ack = 1'b1; else load_ack = 1'b1;
            end
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                check("busy_load_en", 32'(load_en), 32'(kind == 2));
                check("busy_store_en", 32'(store_en), 32'(kind == 3));
            end
            load_ack = 1'b0; store_ack = 1'b0;
            if (kind == 2) begin load_ack = 1'b1; load_error = lerr; end
            else store_ack = 1'b1;
            @(negedge clk);
            load_ack = 1'b0; load_error = 1'b0; store_ack = 1'b0;
            exp_err = (kind == 2) && lerr;
            if (kind == 2 && !lerr) model_valid[a] = 1'b1;
            check("ack_load_en", 32'(load_en), 0);
            check("ack_store_en", 32'(store_en), 0);
            check("ack_done", 32'(done), 32'(!exp_err));
            check("ack_error", 32'(error), 32'(exp_err));
            check("ack_reg_valid", 32'(reg_valid), 32'(model_valid));
            @(negedge clk);
        end
        check("idle_done", 32'(done), 0);
        check("idle_error", 32'(error), 0);
        check("idle_enables", 32'({load_en, store_en}), 0);
        check("idle_ready", 32'(op_ready), 1);
        check("idle_reg_valid", 32'(reg_valid), 32'(model_valid));
    endtask

    // Accept a well-formed LOAD and leave the controller waiting for its ack
    task automatic start_load(input logic a);
        op_valid = 1'b1; op = LOAD; op_addr = a; op_m = 2'd2; op_n = 2'd2;
        @(negedge clk);
        op_valid = 1'b0;
        model_valid[a] = 1'b0;
        check("start_load_en", 32'(load_en), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(op_ready), 0);
        check("rst_pulses", 32'({done, error}), 0);
        check("rst_enables", 32'({load_en, store_en}), 0);
        check("rst_reg_valid", 32'(reg_valid), 0);
        check("rst_addrs", 32'({load_addr, reg_store_addr}), 0);
        check("rst_sizes", 32'({matrix_m_size, matrix_n_size}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(op_ready), 1);

        // Directed scenarios
        run_op(LOAD, 1'b0, 2'd2, 2'd2, 4, 1'b0, 1'b0);
        check("first_load_valid", 32'(reg_valid), 32'b01);
        run_op(STORE, 1'b1, 2'd1, 2'd1, 1, 1'b0, 1'b0);
        run_op(LOAD, 1'b0, 2'd3, 2'd2, 1, 1'b0, 1'b0);
        run_op(LOAD, 1'b0, 2'd1, 2'd0, 1, 1'b0, 1'b0);
        run_op(LOAD, 1'b1, 2'd2, 2'd1, 3, 1'b1, 1'b0);
        run_op(STORE, 1'b1, 2'd2, 2'd1, 1, 1'b0, 1'b0);
        run_op(STORE, 1'b0, 2'd2, 2'd2, 2, 1'b0, 1'b1);
        run_op(NOP, 1'b1, 2'd0, 2'd0, 1, 1'b0, 1'b1);
        run_op(LOAD, 1'b1, 2'd1, 2'd2, 1, 1'b0, 1'b1);

        // Randomized request mix with idle gaps
        for (int t = 0; t < 300; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_ready", 32'(op_ready), 1);
            end
            run_op(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(1, 5)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)));
        end

        // LOAD with no ack ever arriving
        start_load(1'b0);
`ifdef MPU_CTRL_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("wd_load_en_held", 32'(load_en), 1);
        end
        @(negedge clk);
        check("wd_load_en_drop", 32'(load_en), 0);
        check("wd_error", 32'(error), 1);
        check("wd_done", 32'(done), 0);
        check("wd_reg_valid", 32'(reg_valid), 32'(model_valid));
        @(negedge clk);
        check("wd_ready", 32'(op_ready), 1);
        start_load(1'b1);
`else
        for (int i = 1; i < 100; i++) @(negedge clk);
        check("no_wd_load_en", 32'(load_en), 1);
        check("no_wd_pulses", 32'({done, error}), 0);
`endif
        @(negedge clk);
        // Reset in the middle of LOAD_BUSY, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        model_valid = '0;
        check("midrst_load_en", 32'(load_en), 0);
        check("midrst_reg_valid", 32'(reg_valid), 0);
        check("midrst_pulses", 32'({done, error}), 0);
        @(negedge clk);
        check("midrst_hold_pulses", 32'({done, error}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(op_ready), 1);
        check("midrst_after_pulses", 32'({done, error}), 0);
        run_op(STORE, 1'b0, 2'd1, 2'd1, 1, 1'b0, 1'b0);
        run_op(LOAD, 1'b1, 2'd2, 2'd2, 2, 1'b0, 1'b0);
        run_op(STORE, 1'b1, 2'd2, 2'd2, 3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
